// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus between the fetch stage
// (master) and a variable-latency, in-order instruction memory (slave).
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage with prefetch FIFO, response PC queue, stale-response
// discard after redirects, and the IF/ID pipeline register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                 clk,
   input  logic                 reset,
   fetch_stage_if.master        imem,
   input  logic                 StallD,
   input  logic                 FlushD,
   input  logic                 PCSrcE,
   input  logic [31:0]          PCTargetE,
   output logic [31:0]          InstrD,
   output logic [31:0]          PCD,
   output logic [31:0]          PCPlus4D,
   output logic                 ValidD
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   typedef logic [CW-1:0] cnt_t;
   typedef logic [PW-1:0] ptr_t;
   localparam cnt_t        FULL  = FIFO_DEPTH[CW-1:0];
   localparam logic [CW:0] LIMIT = FIFO_DEPTH[CW:0];
   localparam ptr_t        LAST  = ptr_t'(FIFO_DEPTH - 1);

   function automatic ptr_t inc(input ptr_t p);
      return (p == LAST) ? '0 : p + ptr_t'(1);
   endfunction

   logic [31:0] pcf_q, pcf_d;
   cnt_t        out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
   ptr_t        head_q, head_d, tail_q, tail_d, pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
   logic [31:0] fi_q [FIFO_DEPTH];
   logic [31:0] fi_d [FIFO_DEPTH];
   logic [31:0] fp_q [FIFO_DEPTH];
   logic [31:0] fp_d [FIFO_DEPTH];
   logic [31:0] pq_q [FIFO_DEPTH];
   logic [31:0] pq_d [FIFO_DEPTH];
   logic [31:0] dinstr_q, dinstr_d, dpc_q, dpc_d, dpc4_q, dpc4_d;
   logic        dvalid_q, dvalid_d;
   logic        rv, issue, accept, kept, advance, pop, bypass, push;
   logic [CW:0] inflight;
   logic [31:0] rsp_pc, src_pc;

   assign imem.imem_req  = issue;
   assign imem.imem_addr = pcf_q;
   assign InstrD   = dinstr_q;
   assign PCD      = dpc_q;
   assign PCPlus4D = dpc4_q;
   assign ValidD   = dvalid_q;

   always_comb begin
      rv       = imem.imem_rvalid;
      inflight = {1'b0, out_q} + {1'b0, cnt_q};
      issue    = reset && !PCSrcE && (inflight < LIMIT);
      accept   = issue && imem.imem_ready;
      // Responses still owed to a pre-redirect request, or arriving in the redirect cycle, are dropped
      kept     = rv && (drop_q == '0) && !PCSrcE;
      advance  = !PCSrcE && !FlushD && !StallD;
      pop      = advance && (cnt_q != '0);
      bypass   = advance && (cnt_q == '0) && kept;
      push     = kept && !bypass;
      rsp_pc   = pq_q[pq_rd_q];
      pcf_d    = PCSrcE ? PCTargetE : accept ? pcf_q + 32'd4 : pcf_q;
      out_d    = out_q + cnt_t'(accept) - cnt_t'(rv);
      drop_d   = PCSrcE ? out_q - cnt_t'(rv) : (rv && drop_q != '0) ? drop_q - cnt_t'(1) : drop_q;
      fi_d     = fi_q;
      fp_d     = fp_q;
      if (push) begin
         fi_d[tail_q] = imem.imem_rdata;
         fp_d[tail_q] = rsp_pc;
      end
      tail_d   = PCSrcE ? '0 : push ? inc(tail_q) : tail_q;
      head_d   = PCSrcE ? '0 : pop ? inc(head_q) : head_q;
      cnt_d    = PCSrcE ? '0 : cnt_q + cnt_t'(push) - cnt_t'(pop);
      // PC queue pops on every response, kept or dropped, so it stays aligned across redirects
      pq_d     = pq_q;
      if (accept) pq_d[pq_wr_q] = pcf_q;
      pq_wr_d  = accept ? inc(pq_wr_q) : pq_wr_q;
      pq_rd_d  = rv ? inc(pq_rd_q) : pq_rd_q;
      src_pc   = pop ? fp_q[head_q] : rsp_pc;
      dinstr_d = dinstr_q;
      dpc_d    = dpc_q;
      dpc4_d   = dpc4_q;
      dvalid_d = dvalid_q;
      if (PCSrcE || FlushD) begin
         dinstr_d = NOP_INSTR;
         dvalid_d = 1'b0;
      end else if (!StallD) begin
         dvalid_d = pop || bypass;
         dinstr_d = pop ? fi_q[head_q] : bypass ? imem.imem_rdata : NOP_INSTR;
         dpc_d    = (pop || bypass) ? src_pc : dpc_q;
         dpc4_d   = (pop || bypass) ? src_pc + 32'd4 : dpc4_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcf_q    <= RESET_PC;
         out_q    <= '0;
         drop_q   <= '0;
         cnt_q    <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         pq_wr_q  <= '0;
         pq_rd_q  <= '0;
         fi_q     <= '{default: '0};
         fp_q     <= '{default: '0};
         pq_q     <= '{default: '0};
         dinstr_q <= NOP_INSTR;
         dpc_q    <= '0;
         dpc4_q   <= '0;
         dvalid_q <= 1'b0;
      end else begin
         pcf_q    <= pcf_d;
         out_q    <= out_d;
         drop_q   <= drop_d;
         cnt_q    <= cnt_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         pq_wr_q  <= pq_wr_d;
         pq_rd_q  <= pq_rd_d;
         fi_q     <= fi_d;
         fp_q     <= fp_d;
         pq_q     <= pq_d;
         dinstr_q <= dinstr_d;
         dpc_q    <= dpc_d;
         dpc4_q   <= dpc4_d;
         dvalid_q <= dvalid_d;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && !pop && cnt_q == FULL));
   a_no_orphan:   assert property (@(posedge clk) disable iff (!reset) !(rv && out_q == '0));
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized stimulus against an instruction-stream model
// of the fetch stage, with an in-order variable-latency memory responder.
module tb_fetch_stage;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          tag;
   } req_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
   logic [31:0] PCTargetE = '0;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD;
   fetch_stage_if bus();

   fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset), .imem(bus.master),
      .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
   );

   always #5 clk = ~clk;

   int          checks = 0, fails = 0, cyc = 0, epoch = 0, buffered = 0, delivered = 0;
   req_t        pend[$];
   logic [31:0] fpc = RESET_PC, next_pc = RESET_PC;
   logic [31:0] m_instr = NOP, m_pc = '0, m_pc4 = '0;
   logic        m_valid = 1'b0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a >> 2;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_d();
      chk("InstrD", InstrD, m_instr);
      chk("PCD", PCD, m_pc);
      chk("PCPlus4D", PCPlus4D, m_pc4);
      chk("ValidD", 32'(ValidD), 32'(m_valid));
   endtask

   task automatic model_reset();
      pend.delete();
      fpc = RESET_PC; next_pc = RESET_PC; buffered = 0; epoch++;
      m_instr = NOP; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
   endtask

   // One clock cycle: drive at negedge, check fetch side before the edge, update the model, check D
   task automatic cycle(input logic stall, input logic flush, input logic redir,
                        input logic [31:0] tgt, input logic rdy, input int lat_max);
      logic rv, kept, acc, req_exp, consumed;
      req_t h;
      StallD = stall; FlushD = flush; PCSrcE = redir; PCTargetE = tgt; bus.imem_ready = rdy;
      rv = (pend.size() > 0) && (pend[0].due <= cyc);
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rv ? mem(pend[0].addr) : $urandom();
      #1;
      req_exp = !redir && (pend.size() + buffered < DEPTH);
      chk("imem_req", 32'(bus.imem_req), 32'(req_exp));
      chk("imem_addr", bus.imem_addr, fpc);
      acc = bus.imem_req && rdy;
      @(posedge clk);
      kept = 1'b0;
      if (rv) begin
         h = pend.pop_front();
         kept = (h.tag == epoch) && !redir;
      end
      consumed = 1'b0;
      if (redir || flush) begin
         m_valid = 1'b0; m_instr = NOP;
      end else if (!stall) begin
         if (buffered > 0 || kept) begin
            m_valid = 1'b1; m_pc = next_pc; m_pc4 = next_pc + 32'd4; m_instr = mem(next_pc);
            next_pc += 32'd4; consumed = 1'b1; delivered++;
         end else begin
            m_valid = 1'b0; m_instr = NOP;
         end
      end
      buffered = redir ? 0 : buffered + int'(kept) - int'(consumed);
      if (acc) begin
         pend.push_back('{fpc, cyc + int'($urandom_range(lat_max, 1)), epoch});
         fpc += 32'd4;
      end
      if (redir) begin
         epoch++; fpc = tgt; next_pc = tgt;
      end
      cyc++;
      @(negedge clk);
      chk_d();
   endtask

   task automatic run(input int n, input logic stall, input logic rdy, input int lat);
      for (int i = 0; i < n; i++) cycle(stall, 1'b0, 1'b0, '0, rdy, lat);
   endtask

   task automatic pulse_reset();
      reset = 1'b0; bus.imem_rvalid = 1'b0; PCSrcE = 1'b0; StallD = 1'b0; FlushD = 1'b0;
      #1;
      model_reset();
      chk_d();
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_addr", bus.imem_addr, RESET_PC);
      repeat (2) @(negedge clk);
      cyc += 2;
      chk_d();
      chk("rst_req_hold", 32'(bus.imem_req), 32'd0);
      reset = 1'b1;
   endtask

   initial begin
      logic [31:0] t;
      bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
      #2;
      pulse_reset();
      // Streaming at full rate, then a 4-cycle stall
      run(8, 1'b0, 1'b1, 1);
      run(4, 1'b1, 1'b1, 1);
      run(6, 1'b0, 1'b1, 1);
      // Redirect with two long-latency requests in flight
      run(2, 1'b0, 1'b1, 3);
      cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1);
      run(10, 1'b0, 1'b1, 1);
      // Memory not ready for 5 cycles
      run(5, 1'b0, 1'b0, 1);
      run(4, 1'b0, 1'b1, 1);
      // Flush together with stall while the FIFO holds entries
      run(2, 1'b1, 1'b1, 1);
      cycle(1'b1, 1'b1, 1'b0, '0, 1'b1, 1);
      run(6, 1'b0, 1'b1, 1);
      // Redirect with stall near the top of the address space, PC wraps
      cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 2);
      run(8, 1'b0, 1'b1, 1);
      // Reset mid-stream with a non-empty FIFO
      run(2, 1'b1, 1'b1, 1);
      pulse_reset();
      run(6, 1'b0, 1'b1, 1);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         t = $urandom();
         t[1:0] = 2'b00;
         cycle($urandom_range(3, 0) == 0, $urandom_range(11, 0) == 0, $urandom_range(19, 0) == 0,
               t, $urandom_range(9, 0) < 7, int'($urandom_range(4, 1)));
      end
      chk("progress", 32'(delivered > 1000), 32'd1);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
